// File: rtl/mem_model_pkg.sv
// rtl/mem_model_pkg.sv - shared types, default constants and lane helper for mem_model
package mem_model_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;
  localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

  function automatic int unsigned byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_model_latency_ctr.sv
// rtl/mem_model_latency_ctr.sv - accept-to-ready latency counter, one ready pulse per access
module mem_model_latency_ctr
  import mem_model_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o,
  output logic ready_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;

  // BUSY spans the ready cycle too, so a still-high valid cannot be re-accepted there
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= BUSY;
            r_cnt   <= LOAD;
            r_ready <= (LOAD == '0);
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 1'b1;
            r_ready <= (r_cnt == CW'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (r_state == BUSY);
  assign ready_o = r_ready;

endmodule

// File: rtl/mem_model.sv
// rtl/mem_model.sv - word-organised simulation main memory on the iomem valid/ready bus
// Optional byte strobes: define MEM_MODEL_WSTRB_EN to add wr_strb_i.
module mem_model
  import mem_model_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter int unsigned           MEM_DEPTH  = 32'h0004_0000,
  parameter int                    LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(DEF_ERR_DATA)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    wr_enable_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
`ifdef MEM_MODEL_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
`endif
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    cmd_ready_o,
  output logic                    err_o
);

  localparam int LANES      = byte_lanes(DATA_WIDTH);
  localparam int LANE_SHIFT = $clog2(LANES);
  localparam int IW         = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [IW-1:0]         w_mem_idx;
  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_busy;
  logic                  w_ready;

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err;

  assign w_offset   = cmd_addr_i - BASE_ADDR;
  assign w_idx      = w_offset >> LANE_SHIFT;
  assign w_mem_idx  = w_idx[IW-1:0];
  assign w_in_range = (cmd_addr_i >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(MEM_DEPTH));
  assign w_accept   = cmd_valid_i && !w_busy && !w_ready && !rst_i;

  mem_model_latency_ctr #(
    .LATENCY (LATENCY)
  ) u_latency_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_accept),
    .busy_o  (w_busy),
    .ready_o (w_ready)
  );

  // No reset on the array: preloaded program images must survive rst_i
  always_ff @(posedge clk_i) begin
    if (w_accept && wr_enable_i && w_in_range) begin
`ifdef MEM_MODEL_WSTRB_EN
      for (int b = 0; b < LANES; b++) begin
        if (wr_strb_i[b]) begin
          mem_r[w_mem_idx][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
`else
      mem_r[w_mem_idx] <= wr_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_err <= !w_in_range;
      if (w_in_range) begin
        r_rd_data <= mem_r[w_mem_idx];
      end else if (wr_enable_i) begin
        r_rd_data <= '0;
      end else begin
        r_rd_data <= ERR_DATA;
      end
    end
  end

  assign rd_data_o   = r_rd_data;
  assign cmd_ready_o = w_ready;
  assign err_o       = w_ready & r_err;

endmodule

// File: tb/tb_mem_model.sv
// tb/tb_mem_model.sv - randomized bench for mem_model, LATENCY=1 and LATENCY=3 instances side by side
module tb_mem_model;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] DEPTH = 32'h0004_0000;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
  localparam int          NW    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        v1;
  logic        v3;
`ifdef MEM_MODEL_WSTRB_EN
  logic [3:0]  strb;
`endif
  logic [31:0] rd1;
  logic [31:0] rd3;
  logic        rdy1;
  logic        rdy3;
  logic        err1;
  logic        err3;

  logic [31:0] model [0:NW-1];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_model #(.LATENCY(1)) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (v1),
    .cmd_addr_i  (addr),
    .wr_enable_i (we),
    .wr_data_i   (wdata),
`ifdef MEM_MODEL_WSTRB_EN
    .wr_strb_i   (strb),
`endif
    .rd_data_o   (rd1),
    .cmd_ready_o (rdy1),
    .err_o       (err1)
  );

  mem_model #(.LATENCY(3)) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (v3),
    .cmd_addr_i  (addr),
    .wr_enable_i (we),
    .wr_data_i   (wdata),
`ifdef MEM_MODEL_WSTRB_EN
    .wr_strb_i   (strb),
`endif
    .rd_data_o   (rd3),
    .cmd_ready_o (rdy3),
    .err_o       (err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  // One transaction presented to both instances; each master drops valid at its own ready edge
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] g1, g3;
    logic        ge1, ge3;
    int          idx, c1, c3, p1, p3;
    bit          use_s;
`ifdef MEM_MODEL_WSTRB_EN
    use_s = 1'b1;
`else
    use_s = 1'b0;
`endif
    exp_err = !in_range(a);
    idx     = exp_err ? 0 : int'((a - BASE) / 4);
    if (!exp_err) exp_rd = model[idx];
    else          exp_rd = w ? 32'h0 : ERRD;
    if (w && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (!use_s || s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end

    @(negedge clk);
    addr = a; we = w; wdata = d;
`ifdef MEM_MODEL_WSTRB_EN
    strb = s;
`endif
    v1 = 1'b1; v3 = 1'b1;
    c1 = 0; c3 = 0; p1 = 0; p3 = 0;
    g1 = 'x; g3 = 'x; ge1 = 1'bx; ge3 = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (p1 > 0 && c1 == c - 1) v1 = 1'b0;
      if (p3 > 0 && c3 == c - 1) v3 = 1'b0;
      if (rdy1) begin
        p1++;
        if (p1 == 1) begin c1 = c; g1 = rd1; ge1 = err1; end
      end
      if (rdy3) begin
        p3++;
        if (p3 == 1) begin c3 = c; g3 = rd3; ge3 = err3; end
      end
    end
    v1 = 1'b0; v3 = 1'b0;
    check_eq({tag, "/lat1_cycle"}, 32'(c1), 32'd1);
    check_eq({tag, "/lat1_pulses"}, 32'(p1), 32'd1);
    check_eq({tag, "/lat1_rdata"}, g1, exp_rd);
    check_eq({tag, "/lat1_err"}, {31'b0, ge1}, {31'b0, exp_err});
    check_eq({tag, "/lat3_cycle"}, 32'(c3), 32'd3);
    check_eq({tag, "/lat3_pulses"}, 32'(p3), 32'd1);
    check_eq({tag, "/lat3_rdata"}, g3, exp_rd);
    check_eq({tag, "/lat3_err"}, {31'b0, ge3}, {31'b0, exp_err});
  endtask

  task automatic reset_in_busy();
    logic [31:0] d;
    int          p3;
    d = $urandom;
    @(negedge clk);
    addr = BASE + 32'h14; we = 1'b1; wdata = d;
`ifdef MEM_MODEL_WSTRB_EN
    strb = 4'hF;
`endif
    v1 = 1'b1; v3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model[5] = d;
    rst = 1'b1; v1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst/ready3", {31'b0, rdy3}, 32'h0);
    check_eq("rst/rdata3", rd3, 32'h0);
    check_eq("rst/err3", {31'b0, err3}, 32'h0);
    check_eq("rst/rdata1", rd1, 32'h0);
    v3 = 1'b0; rst = 1'b0; p3 = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy3) p3++;
    end
    check_eq("rst/no_pulse", 32'(p3), 32'h0);
    check_eq("rst/written_word", u_dut3.mem_r[5], d);
    check_eq("rst/preload_word", u_dut3.mem_r[0], model[0]);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [31:0] oor [4];
    rst = 1'b1; v1 = 1'b0; v3 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef MEM_MODEL_WSTRB_EN
    strb = '0;
`endif
    for (int i = 0; i < NW; i++) begin
      model[i] = $urandom;
      if (i == 0) model[i] = 32'h0000_0013;
      if (i == 1) model[i] = 32'h1122_3344;
      u_dut1.mem_r[i] = model[i];
      u_dut3.mem_r[i] = model[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("init/ready1", {31'b0, rdy1}, 32'h0);
    check_eq("init/err1", {31'b0, err1}, 32'h0);
    check_eq("init/rdata1", rd1, 32'h0);
    check_eq("init/ready3", {31'b0, rdy3}, 32'h0);
    check_eq("init/rdata3", rd3, 32'h0);
    rst = 1'b0;

    access(1'b0, BASE, 32'h0, 4'hF, "rd_w0");
    check_eq("rd_w0/value", u_dut1.mem_r[0], 32'h0000_0013);
    access(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, "wr_w4");
    access(1'b0, BASE + 32'h10, 32'h0, 4'hF, "rd_w4");
    check_eq("wr_w4/mem", u_dut1.mem_r[4], 32'hCAFE_F00D);
    access(1'b0, 32'h4010_0000, 32'h0, 4'hF, "oor_rd");
    access(1'b1, 32'h4010_0000, 32'h1234_5678, 4'hF, "oor_wr");
    check_eq("oor_wr/mem0_dut1", u_dut1.mem_r[0], model[0]);
    check_eq("oor_wr/mem0_dut3", u_dut3.mem_r[0], model[0]);
`ifdef MEM_MODEL_WSTRB_EN
    access(1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, "strb");
    check_eq("strb/mem1", u_dut1.mem_r[1], 32'h11BB_33DD);
    access(1'b1, BASE + 32'h8, 32'h5555_AAAA, 4'b0000, "strb_none");
    check_eq("strb_none/mem2", u_dut3.mem_r[2], model[2]);
`endif

    reset_in_busy();

    oor[0] = BASE - 32'h4;
    oor[1] = BASE + DEPTH * 4;
    oor[2] = 32'hFFFF_FFFC;
    oor[3] = 32'h0000_0000;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 4) == 0) a = oor[$urandom_range(0, 3)];
      else a = BASE + 32'($urandom_range(0, NW - 1)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      access(1'($urandom_range(0, 1)), a, d, s, $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < NW; i += 9) begin
      check_eq($sformatf("final/mem%0d", i), u_dut3.mem_r[i], model[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
